// File: rtl/prt_dp_pm_hpd_rx_mch_if.sv
// Local bus between the policy maker and its register blocks: 2-bit word address, 32-bit data.
// dout is valid in the cycle that vld is high.
interface prt_dp_lb_if;
  logic [1:0]  ad;
  logic        wr;
  logic        rd;
  logic [31:0] din;
  logic [31:0] dout;
  logic        vld;

  modport lb_in  (input ad, wr, rd, din, output dout, vld);
  modport lb_out (output ad, wr, rd, din, input dout, vld);
endinterface

// File: rtl/prt_dp_pm_hpd_rx_mch.sv
// Multi-channel programmable HPD generator for DP sink ports (plug, unplug, IRQ low pulse).
// Define PRT_DP_PM_HPD_RX_MCH_IRQ_EN to build the sticky done flags, irq_en and IRQ_OUT.
module prt_dp_pm_hpd_rx_mch #(
  parameter int unsigned P_SIM     = 0,
  parameter int unsigned P_CH      = 1,
  parameter int unsigned P_IPW_RST = (P_SIM != 0) ? 5 : 500,
  parameter int unsigned P_HMS_RST = (P_SIM != 0) ? 10 : 2000
) (
  input  logic            CLK_IN,
  input  logic            RST_IN,
  prt_dp_lb_if.lb_in      LB_IF,
  input  logic            BEAT_IN,
  output logic [P_CH-1:0] HPD_OUT,
  output logic            IRQ_OUT
);

  localparam int unsigned CW = 16;
  localparam int unsigned DW = 32;
  localparam logic [1:0]  ADR_CTL = 2'd0;
  localparam logic [1:0]  ADR_CMD = 2'd1;
  localparam logic [1:0]  ADR_STA = 2'd2;
  localparam logic [1:0]  ADR_TIM = 2'd3;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_IDLE = 2'd1,
    ST_IRQ  = 2'd2
  } state_t;

  logic            r_beat_d;
  logic            w_beat_re;
  logic            r_lb_wr;
  logic [1:0]      r_lb_adr;
  logic [DW-1:0]   r_lb_din;
  logic            r_lb_vld;
  logic            w_wr_ctl;
  logic            w_wr_cmd;
  logic            w_wr_sta;
  logic            w_wr_tim;
  logic [DW-1:0]   w_dout;

  logic            r_run;
  logic [CW-1:0]   r_ipw;
  logic [CW-1:0]   r_hms;

  state_t          r_state     [P_CH];
  state_t          w_nxt_state [P_CH];
  logic [CW-1:0]   r_cnt       [P_CH];
  logic [P_CH-1:0] r_pin;
  logic [P_CH-1:0] r_pend_unp;
  logic [P_CH-1:0] r_pend_plg;
  logic [P_CH-1:0] r_pend_irq;
  logic [P_CH-1:0] w_set_unp;
  logic [P_CH-1:0] w_set_plg;
  logic [P_CH-1:0] w_set_irq;
  logic [P_CH-1:0] w_clr_unp;
  logic [P_CH-1:0] w_clr_plg;
  logic [P_CH-1:0] w_clr_irq;
  logic [P_CH-1:0] w_pin_set;
  logic [P_CH-1:0] w_pin_clr;
  logic [P_CH-1:0] w_ld_hms;
  logic [P_CH-1:0] w_ld_ipw;
  logic [P_CH-1:0] w_busy;
  logic [P_CH-1:0] w_done;
  logic            w_irq_en;

`ifdef PRT_DP_PM_HPD_RX_MCH_IRQ_EN
  logic            r_irq_en;
  logic            r_irq;
  logic [P_CH-1:0] r_done;
  logic [P_CH-1:0] w_done_set;
  logic [P_CH-1:0] w_done_clr;
`endif

  // Bus capture: writes take effect one cycle after the bus cycle
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      r_beat_d <= 1'b0;
      r_lb_wr  <= 1'b0;
      r_lb_adr <= '0;
      r_lb_din <= '0;
      r_lb_vld <= 1'b0;
    end else begin
      r_beat_d <= BEAT_IN;
      r_lb_wr  <= LB_IF.wr;
      r_lb_adr <= LB_IF.ad;
      r_lb_din <= LB_IF.din;
      r_lb_vld <= LB_IF.rd;
    end
  end

  assign w_beat_re = BEAT_IN & ~r_beat_d;
  assign w_wr_ctl  = r_lb_wr && (r_lb_adr == ADR_CTL);
  assign w_wr_cmd  = r_lb_wr && (r_lb_adr == ADR_CMD);
  assign w_wr_sta  = r_lb_wr && (r_lb_adr == ADR_STA);
  assign w_wr_tim  = r_lb_wr && (r_lb_adr == ADR_TIM);

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      r_run <= 1'b0;
      r_ipw <= CW'(P_IPW_RST);
      r_hms <= CW'(P_HMS_RST);
    end else begin
      if (w_wr_ctl) r_run <= r_lb_din[0];
      if (w_wr_tim) begin
        r_ipw <= r_lb_din[15:0];
        r_hms <= r_lb_din[31:16];
      end
    end
  end

  // Command decode; out-of-range channels match nothing
  always_comb begin
    w_set_unp = '0;
    w_set_plg = '0;
    w_set_irq = '0;
    for (int n = 0; n < P_CH; n++) begin
      if (w_wr_cmd && r_run && (r_lb_din[1:0] == 2'(n))) begin
        w_set_unp[n] = r_lb_din[2];
        w_set_plg[n] = r_lb_din[3];
        w_set_irq[n] = r_lb_din[4];
      end
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      for (int n = 0; n < P_CH; n++) r_state[n] <= ST_RST;
    end else begin
      for (int n = 0; n < P_CH; n++) r_state[n] <= w_nxt_state[n];
    end
  end

  // Per-channel next state and actions; plug may preempt spacing, unplug/irq wait for it
  always_comb begin
    w_pin_set = '0;
    w_pin_clr = '0;
    w_ld_hms  = '0;
    w_ld_ipw  = '0;
    w_clr_unp = '0;
    w_clr_plg = '0;
    w_clr_irq = '0;
    w_busy    = '0;
`ifdef PRT_DP_PM_HPD_RX_MCH_IRQ_EN
    w_done_set = '0;
`endif
    for (int n = 0; n < P_CH; n++) begin
      w_nxt_state[n] = r_state[n];
      case (r_state[n])
        ST_RST: begin
          w_pin_clr[n]   = 1'b1;
          w_nxt_state[n] = ST_IDLE;
        end
        ST_IDLE: begin
          if (r_pend_unp[n] && (r_cnt[n] == '0)) begin
            w_pin_clr[n] = 1'b1;
            w_clr_unp[n] = 1'b1;
          end else if (r_pend_plg[n]) begin
            w_pin_set[n] = 1'b1;
            w_ld_hms[n]  = 1'b1;
            w_clr_plg[n] = 1'b1;
          end else if (r_pend_irq[n] && (r_cnt[n] == '0)) begin
            w_pin_clr[n]   = 1'b1;
            w_ld_ipw[n]    = 1'b1;
            w_clr_irq[n]   = 1'b1;
            w_nxt_state[n] = ST_IRQ;
          end
        end
        ST_IRQ: begin
          w_busy[n] = 1'b1;
          if (r_cnt[n] == '0) begin
            w_pin_set[n]   = 1'b1;
            w_ld_hms[n]    = 1'b1;
            w_nxt_state[n] = ST_IDLE;
`ifdef PRT_DP_PM_HPD_RX_MCH_IRQ_EN
            w_done_set[n]  = 1'b1;
`endif
          end
        end
        default: w_nxt_state[n] = ST_RST;
      endcase
      if (!r_run) w_nxt_state[n] = ST_RST;
    end
  end

  // Pins, pending flags and counters; run=0 holds everything cleared
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      r_pin      <= '0;
      r_pend_unp <= '0;
      r_pend_plg <= '0;
      r_pend_irq <= '0;
      for (int n = 0; n < P_CH; n++) r_cnt[n] <= '0;
    end else if (!r_run) begin
      r_pin      <= '0;
      r_pend_unp <= '0;
      r_pend_plg <= '0;
      r_pend_irq <= '0;
      for (int n = 0; n < P_CH; n++) r_cnt[n] <= '0;
    end else begin
      r_pin      <= (r_pin & ~w_pin_clr) | w_pin_set;
      r_pend_unp <= (r_pend_unp & ~w_clr_unp) | w_set_unp;
      r_pend_plg <= (r_pend_plg & ~w_clr_plg) | w_set_plg;
      r_pend_irq <= (r_pend_irq & ~w_clr_irq) | w_set_irq;
      for (int n = 0; n < P_CH; n++) begin
        if (w_ld_hms[n])                         r_cnt[n] <= r_hms;
        else if (w_ld_ipw[n])                    r_cnt[n] <= r_ipw;
        else if (w_beat_re && (r_cnt[n] != '0))  r_cnt[n] <= r_cnt[n] - CW'(1);
      end
    end
  end

`ifdef PRT_DP_PM_HPD_RX_MCH_IRQ_EN
  always_comb begin
    w_done_clr = '0;
    for (int n = 0; n < P_CH; n++) w_done_clr[n] = w_wr_sta & r_lb_din[8*n+5];
  end

  // Sticky done: a set in the same cycle as the W1C wins
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      r_irq_en <= 1'b0;
      r_done   <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctl) r_irq_en <= r_lb_din[1];
      r_done <= r_run ? ((r_done & ~w_done_clr) | w_done_set) : '0;
      r_irq  <= r_irq_en & (|r_done);
    end
  end

  assign w_done   = r_done;
  assign w_irq_en = r_irq_en;
  assign IRQ_OUT  = r_irq;
`else
  assign w_done   = '0;
  assign w_irq_en = 1'b0;
  assign IRQ_OUT  = 1'b0;
`endif

  always_comb begin
    w_dout = '0;
    case (r_lb_adr)
      ADR_CTL: w_dout = {30'd0, w_irq_en, r_run};
      ADR_STA: begin
        for (int n = 0; n < P_CH; n++) begin
          w_dout[8*n +: 8] = {2'b00, w_done[n], w_busy[n], r_pend_irq[n],
                              r_pend_plg[n], r_pend_unp[n], r_pin[n]};
        end
      end
      ADR_TIM: w_dout = {r_hms, r_ipw};
      default: w_dout = '0;
    endcase
  end

  assign LB_IF.dout = w_dout;
  assign LB_IF.vld  = r_lb_vld;
  assign HPD_OUT    = r_pin;

endmodule
